// File: rtl/minx16_pkg.sv
// Shared flag-frame definitions for the minx16 core: frame width, bit positions and op decode.
package minx16_pkg;

  localparam int unsigned FLAG_W = 4;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] frame_t;

  typedef enum logic [1:0] {
    OpNone,
    OpPush,
    OpPop,
    OpSwap
  } stack_op_e;

  function automatic frame_t pack_frame(input logic c, input logic n, input logic z,
                                        input logic v);
    frame_t f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/flag_stack_mem.sv
// Flag-frame register file: one synchronous write port, one combinational read port, no reset.
module flag_stack_mem
  import minx16_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = FLAG_W
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flag_stack.sv
// Interrupt flag stack: saves {C,N,Z,V} frames on push and restores them on pop with a
// one-cycle registered restore strobe, plus sticky overflow/underflow indicators.
module flag_stack
  import minx16_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     Cs,
  input  logic                     Ns,
  input  logic                     Zs,
  input  logic                     Vs,
  output logic                     Cbk,
  output logic                     Nbk,
  output logic                     Zbk,
  output logic                     Vbk,
  output logic                     flagRest,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf_err,
  output logic                     unf_err,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [CW-1:0] count_q, count_d;
  frame_t        bk_q, bk_d;
  logic          rest_q, rest_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          mem_we;
  logic [AW-1:0] waddr, raddr;
  frame_t        rdata, live;
  stack_op_e     op;

  assign live  = pack_frame(Cs, Ns, Zs, Vs);
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // Top-of-stack slot; meaningless while empty, never consumed then.
  assign raddr = AW'(count_q - CW'(1));

  always_comb begin
    unique case ({push, pop})
      2'b10:   op = OpPush;
      2'b01:   op = OpPop;
      2'b11:   op = OpSwap;
      default: op = OpNone;
    endcase
  end

  always_comb begin
    count_d = count_q;
    bk_d    = bk_q;
    rest_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;
    mem_we  = 1'b0;
    waddr   = AW'(count_q);
    unique case (op)
      OpPush: begin
        if (!full) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
      OpPop: begin
        if (!empty) begin
          count_d = count_q - CW'(1);
          rest_d  = 1'b1;
          bk_d    = rdata;
        end else begin
          unf_d = 1'b1;
        end
      end
      OpSwap: begin
        if (!empty) begin
          // Restore the old top and replace it in place; depth is unchanged.
          mem_we = 1'b1;
          waddr  = raddr;
          rest_d = 1'b1;
          bk_d   = rdata;
        end else begin
          mem_we  = 1'b1;
          waddr   = '0;
          count_d = CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      bk_q    <= '0;
      rest_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bk_q    <= bk_d;
      rest_q  <= rest_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  flag_stack_mem #(
    .Depth (DEPTH),
    .Width (FLAG_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we & ~rst),
    .waddr_i (waddr),
    .wdata_i (live),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign Cbk      = bk_q[FLAG_C];
  assign Nbk      = bk_q[FLAG_N];
  assign Zbk      = bk_q[FLAG_Z];
  assign Vbk      = bk_q[FLAG_V];
  assign flagRest = rest_q;
  assign count    = count_q;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule

// File: tb/tb_flag_stack.sv
// Self-checking bench for flag_stack: directed scenarios plus randomized traffic against a
// queue-based reference model of the flag stack.
module tb_flag_stack;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, push, pop, clr_err;
  logic       Cs, Ns, Zs, Vs;
  logic       Cbk, Nbk, Zbk, Vbk, flagRest, full, empty, ovf_err, unf_err;
  logic [3:0] count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state.
  logic [3:0] m_stk [$];
  logic [3:0] m_bk;
  logic       m_rest, m_ovf, m_unf;

  always #5 clk = ~clk;

  flag_stack #(
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .Cs       (Cs),
    .Ns       (Ns),
    .Zs       (Zs),
    .Vs       (Vs),
    .Cbk      (Cbk),
    .Nbk      (Nbk),
    .Zbk      (Zbk),
    .Vbk      (Vbk),
    .flagRest (flagRest),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err),
    .clr_err  (clr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] bk_now();
    return {Cbk, Nbk, Zbk, Vbk};
  endfunction

  task automatic model_step(input logic p, input logic q, input logic [3:0] f, input logic c,
                            input logic r);
    if (r) begin
      m_stk.delete();
      m_bk   = 4'h0;
      m_rest = 1'b0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      return;
    end
    m_rest = 1'b0;
    if (c) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (p && q) begin
      if (m_stk.size() > 0) begin
        m_bk                   = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1]  = f;
        m_rest                 = 1'b1;
      end else begin
        m_stk.push_back(f);
        m_unf = 1'b1;
      end
    end else if (p) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(f);
      else m_ovf = 1'b1;
    end else if (q) begin
      if (m_stk.size() > 0) begin
        m_bk   = m_stk.pop_back();
        m_rest = 1'b1;
      end else begin
        m_unf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("count", 32'(count), 32'(m_stk.size()));
    check_eq("full", 32'(full), 32'(m_stk.size() == DEPTH));
    check_eq("empty", 32'(empty), 32'(m_stk.size() == 0));
    check_eq("flagRest", 32'(flagRest), 32'(m_rest));
    check_eq("bk", 32'(bk_now()), 32'(m_bk));
    check_eq("ovf_err", 32'(ovf_err), 32'(m_ovf));
    check_eq("unf_err", 32'(unf_err), 32'(m_unf));
  endtask

  // Drive one cycle from a falling edge, update the model at the rising edge, compare after.
  task automatic step(input logic p, input logic q, input logic [3:0] f, input logic c,
                      input logic r);
    push = p;
    pop = q;
    {Cs, Ns, Zs, Vs} = f;
    clr_err = c;
    rst = r;
    @(posedge clk);
    model_step(p, q, f, c, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    push = 0; pop = 0; clr_err = 0; rst = 1;
    {Cs, Ns, Zs, Vs} = 4'h0;
    m_bk = 4'h0; m_rest = 0; m_ovf = 0; m_unf = 0;
    @(negedge clk);

    // Reset state.
    do_reset();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);

    // Push three frames, pop them back in reverse order on consecutive cycles.
    step(1, 0, 4'b1010, 0, 0);
    step(1, 0, 4'b0101, 0, 0);
    step(1, 0, 4'b1111, 0, 0);
    check_eq("lifo_count3", 32'(count), 32'd3);
    step(0, 1, 4'h0, 0, 0);
    check_eq("lifo_rest1", 32'(flagRest), 32'd1);
    check_eq("lifo_bk1", 32'(bk_now()), 32'hF);
    step(0, 1, 4'h0, 0, 0);
    check_eq("lifo_rest2", 32'(flagRest), 32'd1);
    check_eq("lifo_bk2", 32'(bk_now()), 32'h5);
    step(0, 1, 4'h0, 0, 0);
    check_eq("lifo_rest3", 32'(flagRest), 32'd1);
    check_eq("lifo_bk3", 32'(bk_now()), 32'hA);
    step(0, 0, 4'h0, 0, 0);
    check_eq("lifo_idle_rest", 32'(flagRest), 32'd0);
    check_eq("lifo_hold_bk", 32'(bk_now()), 32'hA);

    // Overflow: nine pushes into an eight-deep stack, then drain.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 4'(i + 1), 0, 0);
      if (i == 7) begin
        check_eq("ovf_full8", 32'(full), 32'd1);
        check_eq("ovf_clear8", 32'(ovf_err), 32'd0);
      end
    end
    check_eq("ovf_set9", 32'(ovf_err), 32'd1);
    check_eq("ovf_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4'h0, 0, 0);
      check_eq("ovf_drain_bk", 32'(bk_now()), 32'(8 - i));
    end

    // Underflow from empty, then clear.
    do_reset();
    step(0, 1, 4'h0, 0, 0);
    check_eq("unf_rest", 32'(flagRest), 32'd0);
    check_eq("unf_set", 32'(unf_err), 32'd1);
    step(0, 0, 4'h0, 1, 0);
    check_eq("unf_clr", 32'(unf_err), 32'd0);
    // Error event in the same cycle as clear wins.
    step(0, 1, 4'h0, 1, 0);
    check_eq("unf_clr_race", 32'(unf_err), 32'd1);

    // Simultaneous push and pop swaps the top frame.
    do_reset();
    step(1, 0, 4'b0011, 0, 0);
    step(1, 1, 4'b1100, 0, 0);
    check_eq("swap_bk", 32'(bk_now()), 32'h3);
    check_eq("swap_count", 32'(count), 32'd1);
    step(0, 1, 4'h0, 0, 0);
    check_eq("swap_pop_bk", 32'(bk_now()), 32'hC);

    // Reset colliding with a pop.
    do_reset();
    step(1, 0, 4'h9, 0, 0);
    step(1, 0, 4'h6, 0, 0);
    step(0, 1, 4'h0, 0, 1);
    check_eq("rstpop_rest", 32'(flagRest), 32'd0);
    check_eq("rstpop_count", 32'(count), 32'd0);
    check_eq("rstpop_bk", 32'(bk_now()), 32'h0);
    step(0, 1, 4'h0, 0, 0);
    check_eq("rstpop_unf", 32'(unf_err), 32'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step(logic'($urandom_range(0, 99) < 50), logic'($urandom_range(0, 99) < 45),
           4'($urandom), logic'($urandom_range(0, 99) < 5), logic'($urandom_range(0, 99) < 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flag_stack.md
FLAG_STACK -- requirements
Module: flag_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the number of 4-bit flag frames held (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 push  input  1  save the current flags as a new frame (interrupt entry).
REQ-005 pop  input  1  restore the top frame (return from interrupt).
REQ-006 Cs, Ns, Zs, Vs  input  1 each  current live flags from the flag register outputs.
REQ-007 Cbk, Nbk, Zbk, Vbk  output  1 each  restored flag values, registered.
REQ-008 flagRest  output  1  one-cycle restore strobe to the flag register.
REQ-009 count  output  $clog2(DEPTH)+1  number of frames held.
REQ-010 full, empty  output  1 each  count==DEPTH and count==0, combinational from count.
REQ-011 ovf_err, unf_err  output  1 each  sticky overflow and underflow indicators.
REQ-012 clr_err  input  1  clears both sticky error bits.

Function
REQ-013 A frame SHALL be packed as {C,N,Z,V}, with C in bit 3.
REQ-014 push only, not full: mem[count] <= {Cs,Ns,Zs,Vs}; count increments; visible next cycle.
REQ-015 push only, full: frame discarded; count unchanged; ovf_err set.
REQ-016 pop only, not empty: count decrements; next cycle flagRest=1 and Cbk..Vbk=mem[count-1].
REQ-017 pop only, empty: count unchanged; flagRest stays 0; Cbk..Vbk unchanged; unf_err set.
REQ-018 push and pop, not empty: Cbk..Vbk <= old top, with flagRest next cycle; top slot overwritten with {Cs,Ns,Zs,Vs}; count unchanged; no error even when full.
REQ-019 push and pop, empty: treated as push only; unf_err set.
REQ-020 Restore latency SHALL be exactly 1 cycle (pop sampled at edge N -> flagRest high in cycle N+1 only).
REQ-021 flagRest SHALL be high for one cycle per accepted pop; back-to-back pops SHALL give consecutive pulses with successive frames.
REQ-022 Cbk..Vbk SHALL hold the last restored frame between pops.
REQ-023 clr_err SHALL clear ovf_err and unf_err next cycle; an error event in the same cycle SHALL win (bit stays set).
REQ-024 count SHALL never exceed DEPTH nor wrap below 0.

Reset
REQ-025 While rst=1 at an edge: count=0, flagRest=0, Cbk=Nbk=Zbk=Vbk=0, ovf_err=0, unf_err=0; push/pop ignored.
REQ-026 Frame storage SHALL NOT require reset; after reset no stale frame SHALL be observable through Cbk..Vbk.
REQ-027 Reset asserted mid-sequence SHALL drop all frames and any pending restore pulse.

Structure
REQ-028 Shared package minx16_pkg SHALL hold FLAG_W=4 and the frame bit-index constants (C=3, N=2, Z=1, V=0).
REQ-029 Storage SHALL be one sub-module, flag_stack_mem: DEPTH x FLAG_W register file, one write port, one combinational read port.
REQ-030 Pointer, error and restore logic SHALL reside in flag_stack.

Verification
REQ-031 Reset, then push flags 1010, 0101, 1111 -> count=3; pop x3 -> flagRest pulses in 3 consecutive cycles; Cbk..Vbk = 1111, 0101, 1010.
REQ-032 DEPTH=8; push 9 frames -> full=1 after the 8th, ovf_err=1 after the 9th; 8 pops return the first 8 frames in reverse order.
REQ-033 From empty, pop -> flagRest=0, unf_err=1, Cbk..Vbk unchanged; clr_err -> unf_err=0 next cycle.
REQ-034 Stack holds 0011 (count=1); push+pop with Cs..Vs=1100 -> flagRest with 0011, count=1; pop -> restores 1100.
REQ-035 Push 2 frames; pop and rst=1 in the same cycle -> no flagRest pulse, count=0, all outputs 0; a following pop sets unf_err.
